// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
//
// This is the memory stage that sits directly after the ALU. The ALU result is
// the effective address and rt is the store data. The unit runs one load or
// store per accepted request over a req/ack data-memory port. Loads return
// sign- or zero-extended data to register writeback. Byte lanes are
// little-endian, so addr[1:0] = 0 selects bits 7:0.
//
// Configuration macro: LSU_MISALIGN_TRAP_EN
//   defined   : a misaligned half or word access faults with cause 01 and
//               issues no memory request.
//   undefined : the low address bits are forced to natural alignment and the
//               access proceeds normally.
//
// Parameter:
//   TIMEOUT_CYCLES : number of ACCESS cycles without mem_ack before a bus-error
//                    fault is raised. 0 disables the timeout.
//
// Ports:
//   clk_cpu      in   CPU clock; all state updates on the rising edge
//   reset        in   asynchronous, active-low reset
//   req_valid    in   request present on op/addr/wdata/rd
//   req_ready    out  unit can accept a request this cycle
//   op           in   MIPS load/store opcode
//   addr         in   effective address
//   wdata        in   store data, right-justified
//   rd           in   load destination register
//   mem_req      out  memory request, held until mem_ack
//   mem_we       out  1 = store
//   mem_addr     out  word address
//   mem_be       out  byte enables
//   mem_wdata    out  store data replicated into the selected lanes
//   mem_ack      in   memory done; mem_rdata is valid in the same cycle
//   mem_rdata    in   load word
//   wb_valid     out  one-cycle pulse: load result on wb_rd/wb_data
//   wb_rd        out  writeback register
//   wb_data      out  extended load data
//   fault        out  one-cycle pulse: request terminated with an error
//   fault_cause  out  01 misaligned, 10 timeout, 11 illegal op; held until
//                     the next fault
// ----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_cpu,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        fault,
    output logic [1:0]  fault_cause
);

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT  = 2'b10;
    localparam logic [1:0] CAUSE_ILLEGAL  = 2'b11;

    // The counter never passes TIMEOUT_CYCLES, so this width always holds it.
    localparam int TW = $clog2(TIMEOUT_CYCLES + 2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_RESP
    } state_t;

    state_t state_q, state_d;

    logic          req_ready_q, req_ready_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          wb_valid_q, wb_valid_d;
    logic [4:0]    wb_rd_q, wb_rd_d;
    logic [31:0]   wb_data_q, wb_data_d;
    logic          fault_q, fault_d;
    logic [1:0]    fault_cause_q, fault_cause_d;

    logic          is_load_q, is_load_d;
    logic [1:0]    ld_size_q, ld_size_d;
    logic          ld_signed_q, ld_signed_d;
    logic [1:0]    ld_off_q, ld_off_d;
    logic [4:0]    rd_q, rd_d;
    logic [TW-1:0] timer_q, timer_d;

    logic          accept;
    logic          in_legal;
    logic          in_load;
    logic          in_signed;
    logic [1:0]    in_size;
    logic          in_misalign;
    logic [1:0]    in_off;
    logic [3:0]    in_be;
    logic [31:0]   in_wdata;
    logic          go_access;
    logic          go_error;
    logic          timeout_hit;
    logic [TW-1:0] timer_inc;

    assign accept = req_valid && req_ready_q;

    // Decode the incoming opcode into access size, direction and signedness.
    always_comb begin
        in_legal  = 1'b1;
        in_load   = 1'b0;
        in_signed = 1'b0;
        in_size   = SZ_BYTE;
        case (op)
            OP_LB:  begin in_load = 1'b1; in_signed = 1'b1; in_size = SZ_BYTE; end
            OP_LH:  begin in_load = 1'b1; in_signed = 1'b1; in_size = SZ_HALF; end
            OP_LW:  begin in_load = 1'b1;                   in_size = SZ_WORD; end
            OP_LBU: begin in_load = 1'b1;                   in_size = SZ_BYTE; end
            OP_LHU: begin in_load = 1'b1;                   in_size = SZ_HALF; end
            OP_SB:  in_size = SZ_BYTE;
            OP_SH:  in_size = SZ_HALF;
            OP_SW:  in_size = SZ_WORD;
            default: in_legal = 1'b0;
        endcase
    end

    // Alignment handling: either trap on misalignment, or round the lane
    // offset down to the natural boundary of the access size.
    always_comb begin
        in_misalign = 1'b0;
        in_off      = addr[1:0];
`ifdef LSU_MISALIGN_TRAP_EN
        if (in_size == SZ_HALF) begin
            in_misalign = addr[0];
        end else if (in_size == SZ_WORD) begin
            in_misalign = (addr[1:0] != 2'b00);
        end
`else
        if (in_size == SZ_HALF) begin
            in_off = {addr[1], 1'b0};
        end else if (in_size == SZ_WORD) begin
            in_off = 2'b00;
        end
`endif
    end

    // Byte enables and lane-replicated store data for the incoming request.
    always_comb begin
        in_be    = 4'b1111;
        in_wdata = wdata;
        case (in_size)
            SZ_BYTE: begin
                in_be    = 4'b0001 << in_off;
                in_wdata = {4{wdata[7:0]}};
            end
            SZ_HALF: begin
                in_be    = 4'b0011 << {in_off[1], 1'b0};
                in_wdata = {2{wdata[15:0]}};
            end
            default: begin
                in_be    = 4'b1111;
                in_wdata = wdata;
            end
        endcase
    end

    assign go_access = accept && in_legal && !in_misalign;
    assign go_error  = accept && (!in_legal || in_misalign);

    // The expiry cycle is the one whose un-acked end would bring the count to
    // TIMEOUT_CYCLES; an ack in that same cycle still completes the access.
    assign timer_inc   = timer_q + TW'(1);
    assign timeout_hit = (TIMEOUT_CYCLES != 0) && !mem_ack &&
                         (timer_inc == TW'(TIMEOUT_CYCLES));

    // Select the addressed lane from the returned word and extend it.
    function automatic logic [31:0] extract_load(
        input logic [31:0] word,
        input logic [1:0]  off,
        input logic [1:0]  size,
        input logic        sgn
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] result;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: result = sgn ? {{24{b[7]}}, b} : {24'd0, b};
            SZ_HALF: result = sgn ? {{16{h[15]}}, h} : {16'd0, h};
            default: result = word;
        endcase
        return result;
    endfunction

    // State register.
    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. RESP accepts like IDLE so requests can overlap.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (go_access) begin
                    state_d = ST_ACCESS;
                end else if (go_error) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (mem_ack || timeout_hit) begin
                    state_d = ST_RESP;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath next values. Every output is registered, so each
    // value is computed for the state being entered.
    always_comb begin
        req_ready_d   = (state_d != ST_ACCESS);
        mem_req_d     = (state_d == ST_ACCESS);
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_be_d      = mem_be_q;
        mem_wdata_d   = mem_wdata_q;
        wb_valid_d    = 1'b0;
        wb_rd_d       = wb_rd_q;
        wb_data_d     = wb_data_q;
        fault_d       = 1'b0;
        fault_cause_d = fault_cause_q;
        is_load_d     = is_load_q;
        ld_size_d     = ld_size_q;
        ld_signed_d   = ld_signed_q;
        ld_off_d      = ld_off_q;
        rd_d          = rd_q;
        timer_d       = '0;

        case (state_q)
            ST_IDLE, ST_RESP: begin
                if (go_access) begin
                    mem_we_d    = !in_load;
                    mem_addr_d  = {addr[31:2], 2'b00};
                    mem_be_d    = in_be;
                    mem_wdata_d = in_wdata;
                    is_load_d   = in_load;
                    ld_size_d   = in_size;
                    ld_signed_d = in_signed;
                    ld_off_d    = in_off;
                    rd_d        = rd;
                end else if (go_error) begin
                    fault_d       = 1'b1;
                    fault_cause_d = in_legal ? CAUSE_MISALIGN : CAUSE_ILLEGAL;
                end
            end
            ST_ACCESS: begin
                timer_d = timer_inc;
                if (mem_ack) begin
                    if (is_load_q) begin
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_data_d  = extract_load(mem_rdata, ld_off_q,
                                                  ld_size_q, ld_signed_q);
                    end
                end else if (timeout_hit) begin
                    fault_d       = 1'b1;
                    fault_cause_d = CAUSE_TIMEOUT;
                end
            end
            default: ;
        endcase
    end

    // Output and datapath registers. req_ready comes out of reset high
    // because the unit starts in IDLE.
    always_ff @(posedge clk_cpu or negedge reset) begin
        if (!reset) begin
            req_ready_q   <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_be_q      <= '0;
            mem_wdata_q   <= '0;
            wb_valid_q    <= 1'b0;
            wb_rd_q       <= '0;
            wb_data_q     <= '0;
            fault_q       <= 1'b0;
            fault_cause_q <= '0;
            is_load_q     <= 1'b0;
            ld_size_q     <= '0;
            ld_signed_q   <= 1'b0;
            ld_off_q      <= '0;
            rd_q          <= '0;
            timer_q       <= '0;
        end else begin
            req_ready_q   <= req_ready_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_be_q      <= mem_be_d;
            mem_wdata_q   <= mem_wdata_d;
            wb_valid_q    <= wb_valid_d;
            wb_rd_q       <= wb_rd_d;
            wb_data_q     <= wb_data_d;
            fault_q       <= fault_d;
            fault_cause_q <= fault_cause_d;
            is_load_q     <= is_load_d;
            ld_size_q     <= ld_size_d;
            ld_signed_q   <= ld_signed_d;
            ld_off_q      <= ld_off_d;
            rd_q          <= rd_d;
            timer_q       <= timer_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign mem_req     = mem_req_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_be      = mem_be_q;
    assign mem_wdata   = mem_wdata_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign fault       = fault_q;
    assign fault_cause = fault_cause_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit, built with TIMEOUT_CYCLES = 4.
// A table of single-transaction vectors drives the main load/store paths, and
// hand-written sequences cover timeout, back-to-back overlap and mid-access
// reset.
module tb_load_store_unit;

    logic        clk_cpu;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        fault;
    logic [1:0]  fault_cause;

    int n_checks;
    int n_errors;

    load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk_cpu    (clk_cpu),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .op         (op),
        .addr       (addr),
        .wdata      (wdata),
        .rd         (rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_be     (mem_be),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .wb_valid   (wb_valid),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .fault      (fault),
        .fault_cause(fault_cause)
    );

    // 10 ns clock.
    initial clk_cpu = 1'b0;
    always #5 clk_cpu = ~clk_cpu;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        err;
        logic [1:0]  cause;
        logic        is_store;
        logic [31:0] maddr;
        logic [3:0]  be;
        logic [31:0] mwdata;
        logic [31:0] wbdata;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic [5:0]  op_i,
        input logic [31:0] addr_i,
        input logic [31:0] wdata_i,
        input logic [4:0]  rd_i,
        input logic [31:0] rdata_i,
        input logic        err_i,
        input logic [1:0]  cause_i,
        input logic        st_i,
        input logic [31:0] maddr_i,
        input logic [3:0]  be_i,
        input logic [31:0] mwdata_i,
        input logic [31:0] wbdata_i
    );
        vec_t v;
        v.op = op_i; v.addr = addr_i; v.wdata = wdata_i; v.rd = rd_i;
        v.rdata = rdata_i; v.err = err_i; v.cause = cause_i;
        v.is_store = st_i; v.maddr = maddr_i; v.be = be_i;
        v.mwdata = mwdata_i; v.wbdata = wbdata_i;
        return v;
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk_cpu);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [5:0] op_i, input logic [31:0] addr_i,
                                 input logic [31:0] wdata_i, input logic [4:0] rd_i);
        op        = op_i;
        addr      = addr_i;
        wdata     = wdata_i;
        rd        = rd_i;
        req_valid = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        reset     = 1'b0;
        req_valid = 1'b0;
        op        = '0;
        addr      = '0;
        wdata     = '0;
        rd        = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;

        // Vector table: op, addr, wdata, rd, rdata, err, cause, store,
        // mem_addr, be, mem_wdata, wb_data.
        vecs.push_back(mk(6'b100000, 32'h103, 32'h0, 5'd3, 32'h80FF_0000, 0, 2'b00, 0, 32'h100, 4'h0, 32'h0, 32'hFFFF_FF80));
        vecs.push_back(mk(6'b100100, 32'h103, 32'h0, 5'd4, 32'h80FF_0000, 0, 2'b00, 0, 32'h100, 4'h0, 32'h0, 32'h0000_0080));
        vecs.push_back(mk(6'b100000, 32'h102, 32'h0, 5'd5, 32'h007F_0000, 0, 2'b00, 0, 32'h100, 4'h0, 32'h0, 32'h0000_007F));
        vecs.push_back(mk(6'b100001, 32'h102, 32'h0, 5'd6, 32'h8001_1234, 0, 2'b00, 0, 32'h100, 4'h0, 32'h0, 32'hFFFF_8001));
        vecs.push_back(mk(6'b100101, 32'h100, 32'h0, 5'd7, 32'h8001_F234, 0, 2'b00, 0, 32'h100, 4'h0, 32'h0, 32'h0000_F234));
        vecs.push_back(mk(6'b100011, 32'h200, 32'h0, 5'd0, 32'hDEAD_BEEF, 0, 2'b00, 0, 32'h200, 4'h0, 32'h0, 32'hDEAD_BEEF));
        vecs.push_back(mk(6'b101001, 32'h202, 32'h1234_ABCD, 5'd0, 32'h0, 0, 2'b00, 1, 32'h200, 4'b1100, 32'hABCD_ABCD, 32'h0));
        vecs.push_back(mk(6'b101000, 32'h301, 32'h0000_00A5, 5'd0, 32'h0, 0, 2'b00, 1, 32'h300, 4'b0010, 32'hA5A5_A5A5, 32'h0));
        vecs.push_back(mk(6'b101011, 32'h404, 32'hCAFE_F00D, 5'd0, 32'h0, 0, 2'b00, 1, 32'h404, 4'b1111, 32'hCAFE_F00D, 32'h0));
        vecs.push_back(mk(6'b101111, 32'h500, 32'h0, 5'd1, 32'h0, 1, 2'b11, 0, 32'h0, 4'h0, 32'h0, 32'h0));
`ifdef LSU_MISALIGN_TRAP_EN
        vecs.push_back(mk(6'b100011, 32'h101, 32'h0, 5'd8, 32'h1122_3344, 1, 2'b01, 0, 32'h0, 4'h0, 32'h0, 32'h0));
        vecs.push_back(mk(6'b100001, 32'h103, 32'h0, 5'd9, 32'hABCD_0000, 1, 2'b01, 0, 32'h0, 4'h0, 32'h0, 32'h0));
`else
        vecs.push_back(mk(6'b100011, 32'h101, 32'h0, 5'd8, 32'h1122_3344, 0, 2'b00, 0, 32'h100, 4'h0, 32'h0, 32'h1122_3344));
        vecs.push_back(mk(6'b100001, 32'h103, 32'h0, 5'd9, 32'hABCD_0000, 0, 2'b00, 0, 32'h100, 4'h0, 32'h0, 32'hFFFF_ABCD));
        vecs.push_back(mk(6'b101001, 32'h203, 32'h0000_5A6B, 5'd0, 32'h0, 0, 2'b00, 1, 32'h200, 4'b1100, 32'h5A6B_5A6B, 32'h0));
`endif

        // Reset state.
        step();
        step();
        checkOutput("rst_req_ready", 32'(req_ready), 32'd1);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("rst_fault", 32'(fault), 32'd0);
        checkOutput("rst_fault_cause", 32'(fault_cause), 32'd0);
        reset = 1'b1;
        step();
        checkOutput("post_rst_req_ready", 32'(req_ready), 32'd1);

        // Table-driven single transactions.
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].op, vecs[i].addr, vecs[i].wdata, vecs[i].rd);
            step();
            req_valid = 1'b0;
            if (vecs[i].err) begin
                checkOutput($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'd0);
                checkOutput($sformatf("v%0d_fault", i), 32'(fault), 32'd1);
                checkOutput($sformatf("v%0d_cause", i), 32'(fault_cause), 32'(vecs[i].cause));
                checkOutput($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'd0);
            end else begin
                checkOutput($sformatf("v%0d_mem_req", i), 32'(mem_req), 32'd1);
                checkOutput($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'd0);
                checkOutput($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].maddr);
                checkOutput($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].is_store));
                if (vecs[i].is_store) begin
                    checkOutput($sformatf("v%0d_mem_be", i), 32'(mem_be), 32'(vecs[i].be));
                    checkOutput($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].mwdata);
                end
                mem_ack   = 1'b1;
                mem_rdata = vecs[i].rdata;
                step();
                mem_ack = 1'b0;
                checkOutput($sformatf("v%0d_mem_req_done", i), 32'(mem_req), 32'd0);
                checkOutput($sformatf("v%0d_fault", i), 32'(fault), 32'd0);
                checkOutput($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'(!vecs[i].is_store));
                if (!vecs[i].is_store) begin
                    checkOutput($sformatf("v%0d_wb_data", i), wb_data, vecs[i].wbdata);
                    checkOutput($sformatf("v%0d_wb_rd", i), 32'(wb_rd), 32'(vecs[i].rd));
                end
            end
            step();
            checkOutput($sformatf("v%0d_idle_ready", i), 32'(req_ready), 32'd1);
            checkOutput($sformatf("v%0d_idle_wb", i), 32'(wb_valid), 32'd0);
            checkOutput($sformatf("v%0d_idle_fault", i), 32'(fault), 32'd0);
        end

        // Timeout: no ack, mem_req stays high for exactly 4 cycles.
        applyStimulus(6'b100011, 32'h500, 32'h0, 5'd10);
        step();
        req_valid = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            checkOutput($sformatf("to_mem_req_c%0d", c), 32'(mem_req), 32'd1);
            checkOutput($sformatf("to_fault_c%0d", c), 32'(fault), 32'd0);
            step();
        end
        checkOutput("to_mem_req_drop", 32'(mem_req), 32'd0);
        checkOutput("to_fault", 32'(fault), 32'd1);
        checkOutput("to_cause", 32'(fault_cause), 32'd2);
        checkOutput("to_wb_valid", 32'(wb_valid), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_AAAA;
        step();
        mem_ack = 1'b0;
        checkOutput("stray_ack_wb", 32'(wb_valid), 32'd0);
        checkOutput("stray_ack_fault", 32'(fault), 32'd0);
        checkOutput("stray_ack_mem_req", 32'(mem_req), 32'd0);
        checkOutput("stray_ack_cause_held", 32'(fault_cause), 32'd2);
        checkOutput("stray_ack_ready", 32'(req_ready), 32'd1);

        // Ack arriving in the expiry cycle completes the load.
        applyStimulus(6'b100011, 32'h504, 32'h0, 5'd11);
        step();
        req_valid = 1'b0;
        step();
        step();
        step();
        checkOutput("exp_mem_req_c4", 32'(mem_req), 32'd1);
        mem_ack   = 1'b1;
        mem_rdata = 32'h0BAD_F00D;
        step();
        mem_ack = 1'b0;
        checkOutput("exp_wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("exp_wb_data", wb_data, 32'h0BAD_F00D);
        checkOutput("exp_fault", 32'(fault), 32'd0);
        step();

        // Back-to-back SW then LW with zero-wait memory.
        mem_ack   = 1'b1;
        mem_rdata = 32'h7654_3210;
        applyStimulus(6'b101011, 32'h600, 32'h1357_9BDF, 5'd0);
        step();
        checkOutput("b2b_sw_mem_req", 32'(mem_req), 32'd1);
        checkOutput("b2b_sw_mem_we", 32'(mem_we), 32'd1);
        applyStimulus(6'b100011, 32'h604, 32'h0, 5'd12);
        step();
        checkOutput("b2b_resp_ready", 32'(req_ready), 32'd1);
        checkOutput("b2b_sw_no_wb", 32'(wb_valid), 32'd0);
        checkOutput("b2b_sw_no_fault", 32'(fault), 32'd0);
        step();
        req_valid = 1'b0;
        checkOutput("b2b_lw_mem_req", 32'(mem_req), 32'd1);
        checkOutput("b2b_lw_mem_we", 32'(mem_we), 32'd0);
        checkOutput("b2b_lw_mem_addr", mem_addr, 32'h604);
        step();
        mem_ack = 1'b0;
        checkOutput("b2b_lw_wb_valid", 32'(wb_valid), 32'd1);
        checkOutput("b2b_lw_wb_data", wb_data, 32'h7654_3210);
        checkOutput("b2b_lw_wb_rd", 32'(wb_rd), 32'd12);
        step();

        // Reset asserted mid-access.
        applyStimulus(6'b100011, 32'h700, 32'h0, 5'd13);
        step();
        req_valid = 1'b0;
        checkOutput("mr_mem_req_before", 32'(mem_req), 32'd1);
        reset = 1'b0;
        #1;
        checkOutput("mr_mem_req_async", 32'(mem_req), 32'd0);
        @(negedge clk_cpu);
        reset = 1'b1;
        step();
        checkOutput("mr_ready", 32'(req_ready), 32'd1);
        checkOutput("mr_wb_valid", 32'(wb_valid), 32'd0);
        checkOutput("mr_fault", 32'(fault), 32'd0);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        checkOutput("mr_late_ack_wb", 32'(wb_valid), 32'd0);
        checkOutput("mr_late_ack_mem_req", 32'(mem_req), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
